if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Parametrised instruction-fetch stage for the MIPS CPU: owns the program counter, drives the instruction memory with a request/acknowledge handshake, and delivers fetched instructions with their PCs to the decode stage. It supports variable-latency memory, decode back-pressure (stall), and branch/jump redirect with flush.

## Interface
- PC_LENGTH, 32: PC / address width in bits.
- INST_WIDTH, 32: instruction word width.
- PC_STEP, 4: PC increment per sequential fetch; power of two.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  decode not ready; output held while instValid is high.
- branchEn  in  1  redirect request this cycle.
- branchAddr  in  PC_LENGTH  redirect target.
- romCe  out  1  instruction-memory request (chip enable).
- romAddr  out  PC_LENGTH  fetch address; always equals pc.
- romAck  in  1  memory returns romData this cycle.
- romData  in  INST_WIDTH  fetched word.
- pc  out  PC_LENGTH  current fetch PC.
- instValid  out  1  inst/instPc hold a valid instruction.
- inst  out  INST_WIDTH  instruction to decode.
- instPc  out  PC_LENGTH  PC of inst.

## Operation
- States: BOOT, REQ, HOLD.
- Reset (asynchronous, immediate): pc=RESET_PC, romCe=0, instValid=0, inst=0, instPc=0, holding register cleared, state=BOOT.
- BOOT: romCe=0; at the next edge go to REQ.
- REQ: romCe=1. On an edge where romAck=1:
  - If the output slot is free (instValid=0) or being consumed (stall=0): inst<=romData, instPc<=pc, instValid<=1, pc<=pc+PC_STEP; stay in REQ.
  - Otherwise: capture romData/pc in the holding register, pc<=pc+PC_STEP, go to HOLD.
- REQ, romAck=0: if instValid=1 and stall=0, instValid<=0.
- HOLD: romCe=0. On stall=0, move the holding register to the output (instValid stays 1) and go to REQ.
- A consumption event is an edge with instValid=1 and stall=0.
- branchEn (highest priority, any state except BOOT):
  - pc<=branchAddr with the low log2(PC_STEP) bits forced to 0.
  - instValid<=0; holding register discarded.
  - state<=REQ.
  - A romAck in the same cycle is ignored.
- branchEn in BOOT: pc is loaded, and the state still moves to REQ.
- PC arithmetic is modulo 2^PC_LENGTH. Increment past all-ones wraps to 0 with no flag.
- inst and instPc are unchanged while instValid=0; only instValid qualifies them.

## Timing
- Reset release to the first request: romCe rises after the first edge following rst deassertion (the BOOT cycle).
- Fetch latency: romAck at edge N gives instValid=1 from edge N. With zero-wait memory (romAck tied 1), the first instValid appears after the second edge post-reset.
- Throughput: one instruction per cycle with romAck=1 and stall=0.
- A stall costs no lost fetch. At most 2 instructions are buffered (output plus holding). romCe drops while HOLD is occupied.
- Redirect penalty: one cycle; the first target request is issued the cycle after branchEn.
- Simultaneous stall and branchEn: the branch wins and the output is flushed.
- Simultaneous romAck and HOLD→REQ: impossible, because romCe=0 in HOLD.
- Outputs are registered; no combinational path from stall, romAck or branchEn to any output except romAddr via pc (itself registered).

## Structure
- Shared define header if_defs.vh holds:
  - ENABLE/DISABLE levels.
  - State encodings BOOT/REQ/HOLD (2-bit).
  - Default PC_LENGTH, PC_STEP and INST_WIDTH values.
- One natural sub-module: if_skid_buf, the two-entry output/holding buffer with load/consume/flush controls. The FSM and PC register stay in the top level.

## Test plan
- Reset and boot: RESET_PC=0x00400000; release rst with romAck=1 and stall=0 → romCe=0 for one cycle, then instPc sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles with inst=romData.
- Back-pressure: stall=1 for 3 cycles while instValid=1 → the second word is captured in HOLD and romCe=0. On release, instPc continues with no skipped or duplicated PC.
- Wait states: romAck low for 2 cycles per request → instValid pulses once per 3 cycles and pc advances only on ack.
- Redirect: branchEn with branchAddr=0x00000103 in the same cycle as romAck and stall=1 → instValid=0 next cycle, then instPc=0x00000100 and the acked word is discarded.
- Wrap and async reset: PC_LENGTH=8, pc=0xFC, ack → pc=0x00. Assert rst mid-HOLD between edges → all outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared levels, defaults and state encoding for the fetch stage
package if_fetch_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DEF_PC_LENGTH  = 32;
  localparam int DEF_PC_STEP    = 4;
  localparam int DEF_INST_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - two-entry output/holding buffer between memory and decode
module if_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int PC_LENGTH  = DEF_PC_LENGTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  park_i,
  input  logic                  unpark_i,
  input  logic                  drop_i,
  input  logic                  flush_i,
  input  logic [INST_WIDTH-1:0] data_i,
  input  logic [PC_LENGTH-1:0]  pc_i,
  output logic                  valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_LENGTH-1:0]  inst_pc_o
);

  logic                  out_valid_q;
  logic [INST_WIDTH-1:0] out_inst_q;
  logic [PC_LENGTH-1:0]  out_pc_q;
  logic                  hold_valid_q;
  logic [INST_WIDTH-1:0] hold_inst_q;
  logic [PC_LENGTH-1:0]  hold_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= DISABLE;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      hold_valid_q <= DISABLE;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
    end else if (flush_i) begin
      // Data words are left stale; only the valid bits matter after a flush.
      out_valid_q  <= DISABLE;
      hold_valid_q <= DISABLE;
    end else begin
      if (load_i) begin
        out_inst_q  <= data_i;
        out_pc_q    <= pc_i;
        out_valid_q <= ENABLE;
      end else if (unpark_i && hold_valid_q) begin
        out_inst_q   <= hold_inst_q;
        out_pc_q     <= hold_pc_q;
        out_valid_q  <= ENABLE;
        hold_valid_q <= DISABLE;
      end else if (drop_i) begin
        out_valid_q <= DISABLE;
      end
      if (park_i) begin
        hold_inst_q  <= data_i;
        hold_pc_q    <= pc_i;
        hold_valid_q <= ENABLE;
      end
    end
  end

  assign valid_o   = out_valid_q;
  assign inst_o    = out_inst_q;
  assign inst_pc_o = out_pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC register, fetch FSM and memory handshake for the instruction-fetch stage
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                 PC_LENGTH  = DEF_PC_LENGTH,
  parameter int                 INST_WIDTH = DEF_INST_WIDTH,
  parameter int                 PC_STEP    = DEF_PC_STEP,
  parameter logic [PC_LENGTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branchEn,
  input  logic [PC_LENGTH-1:0]  branchAddr,
  output logic                  romCe,
  output logic [PC_LENGTH-1:0]  romAddr,
  input  logic                  romAck,
  input  logic [INST_WIDTH-1:0] romData,
  output logic [PC_LENGTH-1:0]  pc,
  output logic                  instValid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_LENGTH-1:0]  instPc
);

  localparam logic [PC_LENGTH-1:0] STEP       = PC_LENGTH'(PC_STEP);
  localparam logic [PC_LENGTH-1:0] ALIGN_MASK = ~PC_LENGTH'(PC_STEP - 1);

  fetch_state_e          state_q, state_d;
  logic [PC_LENGTH-1:0]  pc_q, pc_d;
  logic                  rom_ce_q, rom_ce_d;
  logic                  load, park, unpark, drop, flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    park    = 1'b0;
    unpark  = 1'b0;
    drop    = 1'b0;
    flush   = 1'b0;
    // A redirect overrides everything, including an ack arriving in the same cycle.
    if (branchEn) begin
      pc_d    = branchAddr & ALIGN_MASK;
      flush   = 1'b1;
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_REQ;
        ST_REQ: begin
          if (romAck) begin
            pc_d = pc_q + STEP;
            if (!instValid || !stall) begin
              load = 1'b1;
            end else begin
              park    = 1'b1;
              state_d = ST_HOLD;
            end
          end else if (instValid && !stall) begin
            drop = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            unpark  = 1'b1;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
    rom_ce_d = (state_d == ST_REQ) ? ENABLE : DISABLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      rom_ce_q <= DISABLE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rom_ce_q <= rom_ce_d;
    end
  end

  if_skid_buf #(
    .PC_LENGTH (PC_LENGTH),
    .INST_WIDTH(INST_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .park_i   (park),
    .unpark_i (unpark),
    .drop_i   (drop),
    .flush_i  (flush),
    .data_i   (romData),
    .pc_i     (pc_q),
    .valid_o  (instValid),
    .inst_o   (inst),
    .inst_pc_o(instPc)
  );

  assign romCe   = rom_ce_q;
  assign romAddr = pc_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branchEn, romAck;
  logic [31:0] branchAddr;
  logic        romCe, instValid;
  logic [31:0] romAddr, romData, pc, inst, instPc;

  logic        rst2, stall2, branchEn2, romAck2;
  logic [7:0]  branchAddr2;
  logic        romCe2, instValid2;
  logic [7:0]  romAddr2, pc2, instPc2;
  logic [31:0] romData2, inst2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign romData  = rom_word(romAddr);
  assign romData2 = rom_word({24'h0, romAddr2});

  if_fetch_unit #(.PC_LENGTH(32), .INST_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branchEn(branchEn), .branchAddr(branchAddr),
    .romCe(romCe), .romAddr(romAddr), .romAck(romAck), .romData(romData),
    .pc(pc), .instValid(instValid), .inst(inst), .instPc(instPc)
  );

  if_fetch_unit #(.PC_LENGTH(8), .INST_WIDTH(32), .PC_STEP(4), .RESET_PC(8'hF8)) dut8 (
    .clk(clk), .rst(rst2), .stall(stall2), .branchEn(branchEn2), .branchAddr(branchAddr2),
    .romCe(romCe2), .romAddr(romAddr2), .romAck(romAck2), .romData(romData2),
    .pc(pc2), .instValid(instValid2), .inst(inst2), .instPc(instPc2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; branchEn = 1'b0; branchAddr = '0; romAck = 1'b1;
    rst2 = 1'b1; stall2 = 1'b0; branchEn2 = 1'b0; branchAddr2 = '0; romAck2 = 1'b1;
    repeat (2) tick();
    total++; if (romCe !== 1'b0) begin bad++; $display("FAIL reset_romCe got=%0h want=0", romCe); end
    total++; if (instValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", instValid); end
    total++; if (pc !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc got=%0h want=400000", pc); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%0h want=0", inst); end
    total++; if (instPc !== 32'h0) begin bad++; $display("FAIL reset_instPc got=%0h want=0", instPc); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (romCe !== 1'b0) begin bad++; $display("FAIL boot_romCe got=%0h want=0", romCe); end
    tick();
    total++; if (romCe !== 1'b1) begin bad++; $display("FAIL first_req_romCe got=%0h want=1", romCe); end
    total++; if (instValid !== 1'b0) begin bad++; $display("FAIL first_req_valid got=%0h want=0", instValid); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0040_0000 + 32'(4 * i);
      tick();
      total++; if (instValid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0h want=1", i, instValid); end
      total++; if (instPc !== exp_pc) begin bad++; $display("FAIL stream_instPc[%0d] got=%0h want=%0h", i, instPc, exp_pc); end
      total++; if (inst !== rom_word(exp_pc)) begin bad++; $display("FAIL stream_inst[%0d] got=%0h want=%0h", i, inst, rom_word(exp_pc)); end
    end
  endtask

  task automatic test_backpressure;
    stall = 1'b1;
    tick();
    total++; if (romCe !== 1'b0) begin bad++; $display("FAIL bp_romCe got=%0h want=0", romCe); end
    total++; if (instPc !== 32'h0040_0008) begin bad++; $display("FAIL bp_instPc got=%0h want=400008", instPc); end
    total++; if (pc !== 32'h0040_0010) begin bad++; $display("FAIL bp_pc got=%0h want=400010", pc); end
    repeat (2) begin
      tick();
      total++; if (instPc !== 32'h0040_0008 || instValid !== 1'b1) begin bad++; $display("FAIL bp_held got=%0h/%0h want=400008/1", instPc, instValid); end
      total++; if (romCe !== 1'b0) begin bad++; $display("FAIL bp_held_romCe got=%0h want=0", romCe); end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (instPc !== 32'h0040_000C + 32'(4 * i) || instValid !== 1'b1) begin
        bad++; $display("FAIL bp_release[%0d] got=%0h/%0h want=%0h/1", i, instPc, instValid, 32'h0040_000C + 32'(4 * i));
      end
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] exp_pc;
    exp_pc = 32'h0040_0018;
    for (int r = 0; r < 2; r++) begin
      romAck = 1'b0;
      repeat (2) begin
        tick();
        total++; if (instValid !== 1'b0) begin bad++; $display("FAIL ws_idle_valid[%0d] got=%0h want=0", r, instValid); end
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL ws_idle_pc[%0d] got=%0h want=%0h", r, pc, exp_pc); end
      end
      romAck = 1'b1;
      tick();
      total++; if (instValid !== 1'b1 || instPc !== exp_pc) begin bad++; $display("FAIL ws_ack[%0d] got=%0h/%0h want=1/%0h", r, instValid, instPc, exp_pc); end
      total++; if (inst !== rom_word(exp_pc)) begin bad++; $display("FAIL ws_inst[%0d] got=%0h want=%0h", r, inst, rom_word(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL ws_pc[%0d] got=%0h want=%0h", r, pc, exp_pc); end
    end
  endtask

  task automatic test_redirect;
    stall = 1'b1; branchEn = 1'b1; branchAddr = 32'h0000_0103;
    tick();
    total++; if (instValid !== 1'b0) begin bad++; $display("FAIL br_flush_valid got=%0h want=0", instValid); end
    total++; if (pc !== 32'h0000_0100) begin bad++; $display("FAIL br_pc got=%0h want=100", pc); end
    total++; if (romCe !== 1'b1) begin bad++; $display("FAIL br_romCe got=%0h want=1", romCe); end
    branchEn = 1'b0; stall = 1'b0;
    tick();
    total++; if (instValid !== 1'b1 || instPc !== 32'h0000_0100) begin bad++; $display("FAIL br_target got=%0h/%0h want=1/100", instValid, instPc); end
    total++; if (inst !== rom_word(32'h0000_0100)) begin bad++; $display("FAIL br_inst got=%0h want=%0h", inst, rom_word(32'h100)); end
    tick();
    total++; if (instPc !== 32'h0000_0104) begin bad++; $display("FAIL br_next got=%0h want=104", instPc); end
  endtask

  task automatic test_redirect_hold;
    stall = 1'b1;
    tick();
    total++; if (romCe !== 1'b0) begin bad++; $display("FAIL brh_hold_romCe got=%0h want=0", romCe); end
    branchEn = 1'b1; branchAddr = 32'h0000_0200;
    tick();
    total++; if (instValid !== 1'b0 || pc !== 32'h0000_0200) begin bad++; $display("FAIL brh_flush got=%0h/%0h want=0/200", instValid, pc); end
    branchEn = 1'b0; stall = 1'b0;
    tick();
    total++; if (instPc !== 32'h0000_0200) begin bad++; $display("FAIL brh_target got=%0h want=200", instPc); end
    tick();
    total++; if (instPc !== 32'h0000_0204) begin bad++; $display("FAIL brh_no_stale got=%0h want=204", instPc); end
  endtask

  task automatic test_async_reset;
    stall = 1'b1;
    tick();
    total++; if (romCe !== 1'b0 || instValid !== 1'b1) begin bad++; $display("FAIL ar_hold got=%0h/%0h want=0/1", romCe, instValid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (instValid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h want=0", instValid); end
    total++; if (pc !== 32'h0040_0000) begin bad++; $display("FAIL ar_pc got=%0h want=400000", pc); end
    total++; if (instPc !== 32'h0 || inst !== 32'h0) begin bad++; $display("FAIL ar_outs got=%0h/%0h want=0/0", instPc, inst); end
    total++; if (romCe !== 1'b0) begin bad++; $display("FAIL ar_romCe got=%0h want=0", romCe); end
    tick();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    tick();
    total++; if (romCe !== 1'b1 || instValid !== 1'b0) begin bad++; $display("FAIL ar_reboot got=%0h/%0h want=1/0", romCe, instValid); end
    tick();
    total++; if (instPc !== 32'h0040_0000 || instValid !== 1'b1) begin bad++; $display("FAIL ar_first got=%0h/%0h want=400000/1", instPc, instValid); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (3) tick();
    total++; if (pc2 !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%0h want=0", pc2); end
    total++; if (instPc2 !== 8'hFC || inst2 !== rom_word(32'hFC)) begin bad++; $display("FAIL wrap_last got=%0h/%0h want=fc/%0h", instPc2, inst2, rom_word(32'hFC)); end
    tick();
    total++; if (instPc2 !== 8'h00 || pc2 !== 8'h04) begin bad++; $display("FAIL wrap_next got=%0h/%0h want=0/4", instPc2, pc2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect();
    test_redirect_hold();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
